serial_word_rx: RTL and testbench
=================================

SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per serial word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-word buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sin  input  1  serial data bit, LSB first.
REQ-006 SHALL have port sin_valid  input  1  sin qualifier; one bit per high cycle.
REQ-007 SHALL have port sof  input  1  start-of-frame; meaningful only with sin_valid; marks bit 0.
REQ-008 SHALL have port out_data  output  WORD_W  head-of-buffer word.
REQ-009 SHALL have port out_valid  output  1  buffer non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accept; pop when out_valid&&out_ready.
REQ-011 SHALL have port busy  output  1  high while a frame is partially received.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse: completed word dropped, buffer full.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse: partial frame aborted by new sof.
REQ-014 SHALL have port parity_err  output  1  one-cycle pulse on bad parity (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, PAR; reset state IDLE.
REQ-016 IDLE: sin_valid&&sof SHALL capture bit 0, set bit count 1, go SHIFT; sin_valid without sof SHALL be ignored.
REQ-017 SHIFT: each sin_valid SHALL right-shift sin into the MSB of the shift register and increment count; idle cycles hold state.
REQ-018 On accepting bit WORD_W-1 the FSM SHALL go PAR when parity compiled in, else commit the word at that edge and go IDLE.
REQ-019 Committed word SHALL appear on out_data/out_valid the cycle after the committing edge (latency 1 from last accepted bit).
REQ-020 sof with sin_valid in SHIFT or PAR SHALL discard the partial word, pulse frame_err next cycle, and restart with that bit as bit 0.
REQ-021 Buffer full at commit with no pop that cycle SHALL drop the word and pulse overflow; buffer contents unchanged.
REQ-022 Buffer full with simultaneous pop and commit SHALL accept both; count unchanged.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits so full and empty are distinct.
REQ-024 out_data SHALL be stable while out_valid&&!out_ready; pop on empty SHALL be ignored.
REQ-025 busy SHALL equal (state != IDLE).

Reset
REQ-026 rst SHALL force state IDLE, count 0, shift register 0, buffer pointers/count 0, out_valid 0, out_data 0, busy 0, and all pulses 0.
REQ-027 rst mid-frame SHALL discard the partial word and all buffered words, with no error pulse.

Configuration
REQ-028 With SERIAL_WORD_RX_PARITY_EN defined, each frame SHALL carry one extra even-parity bit after bit WORD_W-1; in PAR the next sin_valid checks it, commits on match, else drops word and pulses parity_err; then IDLE.
REQ-029 Without SERIAL_WORD_RX_PARITY_EN, PAR SHALL be unreachable, frames are WORD_W bits, parity_err SHALL be tied 0.

Structure
REQ-030 Shared package serial_pkg SHALL hold WORD_W/FIFO_DEPTH defaults and the FSM state typedef (IDLE, SHIFT, PAR).
REQ-031 Buffer SHALL be sub-module rx_word_fifo (push, pop, data, count, full, empty); FSM and shifter stay in the top.

Verification
REQ-032 Reset, send 8'hA5 LSB-first (sof on first bit) contiguously -> out_valid high one cycle after last bit, out_data 8'hA5, busy low.
REQ-033 Send 8'h3C with sin_valid gaps every other cycle -> out_data 8'h3C, no error pulses.
REQ-034 out_ready=0, send 5 words 01,02,03,04,05 -> fifth pulses overflow; then drain yields 01,02,03,04.
REQ-035 Send 4 bits of 8'hFF, then sof+full 8'h12 -> frame_err one pulse, only 8'h12 received.
REQ-036 Buffer full, commit and pop same cycle -> no overflow, count stays 4, order preserved.
REQ-037 With SERIAL_WORD_RX_PARITY_EN, send 8'h07 with parity 1 -> received; with parity 0 -> parity_err pulse, nothing buffered.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared defaults and FSM state type for the serial word receiver.
package serial_pkg;

    localparam int WORD_W_DEFAULT     = 8;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } rx_state_t;

endpackage

// File: rtl/rx_word_fifo.sv
// Received-word buffer: power-of-two circular store, head word presented
// combinationally (zero while empty), pop on empty ignored.
module rx_word_fifo
    import serial_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] in_data,
    output logic [WORD_W-1:0] out_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              do_push;
    logic              do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);
    assign count = count_reg;

    // A pop frees the slot a same-cycle push needs, so full+pop+push is legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= in_data;
    end

    assign out_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/serial_word_rx.sv
// LSB-first serial word receiver with sof framing and an output word buffer.
// Optional even-parity bit per frame when SERIAL_WORD_RX_PARITY_EN is defined.
module serial_word_rx
    import serial_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_valid,
    input  logic              sof,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int             CNT_W    = $clog2(WORD_W + 1);
    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    rx_state_t         state_reg;
    rx_state_t         state_next;
    logic [WORD_W-1:0] shreg_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [WORD_W-1:0] shifted;

    logic              start_frame;
    logic              shift_bit;
    logic              push;
    logic [WORD_W-1:0] push_data;
    logic              frame_err_next;
    logic              parity_err_next;
    logic              overflow_next;

    logic              frame_err_reg;
    logic              overflow_reg;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W:0]    fifo_count;
    logic              unused_count;

    assign shifted = {sin, shreg_reg[WORD_W-1:1]};
    wire   last_bit = (bit_cnt_reg == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (sin_valid && sof) state_next = SHIFT;
            end
            SHIFT: begin
                if (sin_valid && !sof && last_bit) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
                    state_next = PAR;
`else
                    state_next = IDLE;
`endif
                end
            end
            PAR: begin
                if (sin_valid) state_next = sof ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_frame     = 1'b0;
        shift_bit       = 1'b0;
        push            = 1'b0;
        push_data       = shifted;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                start_frame = sin_valid && sof;
            end
            SHIFT: begin
                if (sin_valid) begin
                    if (sof) begin
                        start_frame    = 1'b1;
                        frame_err_next = 1'b1;
                    end else begin
                        shift_bit = 1'b1;
`ifndef SERIAL_WORD_RX_PARITY_EN
                        push = last_bit;
`endif
                    end
                end
            end
            PAR: begin
                if (sin_valid) begin
                    if (sof) begin
                        start_frame    = 1'b1;
                        frame_err_next = 1'b1;
                    end else begin
`ifdef SERIAL_WORD_RX_PARITY_EN
                        // Even parity: data bits plus parity bit XOR to zero.
                        push_data = shreg_reg;
                        if (sin == ^shreg_reg) push = 1'b1;
                        else                   parity_err_next = 1'b1;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (start_frame) begin
            shreg_reg   <= {sin, {(WORD_W-1){1'b0}}};
            bit_cnt_reg <= CNT_W'(1);
        end else if (shift_bit) begin
            shreg_reg   <= shifted;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
    end

    // A full buffer can only be relieved by a pop in the same cycle.
    assign overflow_next = push && fifo_full && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            frame_err_reg <= frame_err_next;
            overflow_reg  <= overflow_next;
        end
    end

`ifdef SERIAL_WORD_RX_PARITY_EN
    logic parity_err_reg;
    always_ff @(posedge clk) begin
        if (rst) parity_err_reg <= 1'b0;
        else     parity_err_reg <= parity_err_next;
    end
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    rx_word_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (out_ready),
        .in_data  (push_data),
        .out_data (out_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign unused_count = ^{fifo_count, parity_err_next};

    assign out_valid = !fifo_empty;
    assign busy      = (state_reg != IDLE);
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed and randomized bench for serial_word_rx against a queue-based
// reference model of the received-word buffer.
module tb_serial_word_rx;

    localparam int W     = 8;
    localparam int DEPTH = 4;
`ifdef SERIAL_WORD_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int F = W + PB;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_valid;
    logic         sof;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         overflow;
    logic         frame_err;
    logic         parity_err;

    serial_word_rx #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sof        (sof),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    int           ovf_cnt = 0;
    int           ferr_cnt = 0;
    int           perr_cnt = 0;
    bit           partial = 0;
    logic [W-1:0] model_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check head of buffer, advance model.
    task automatic cycle(input bit v, input bit b, input bit s, input bit rdy,
                         input bit commit, input logic [W-1:0] word,
                         input bit exp_ferr, input bit exp_perr, input bit exp_busy);
        bit pop;
        bit full_before;
        bit exp_ovf;
        sin = b; sin_valid = v; sof = s; out_ready = rdy;
        check("out_valid", out_valid, model_q.size() != 0);
        if (model_q.size() != 0) check("out_data", out_data, model_q[0]);
        pop         = rdy && (model_q.size() != 0);
        full_before = (model_q.size() == DEPTH);
        @(posedge clk);
        #1;
        exp_ovf = 0;
        if (pop) void'(model_q.pop_front());
        if (commit) begin
            if (!full_before || pop) model_q.push_back(word);
            else exp_ovf = 1;
        end
        if (overflow)   ovf_cnt++;
        if (frame_err)  ferr_cnt++;
        if (parity_err) perr_cnt++;
        check("overflow", overflow, exp_ovf);
        check("frame_err", frame_err, exp_ferr);
        check("parity_err", parity_err, exp_perr);
        check("busy", busy, exp_busy);
        sin_valid = 0; sof = 0; out_ready = 0;
    endtask

    // gap_mode: 0 none, 1 idle between bits, 2 random. rdy_mode: 0 low, 1 high,
    // 2 random, 3 high only on the last bit.
    task automatic send_frame(input logic [W-1:0] word, input int nbits,
                              input int gap_mode, input int rdy_mode, input bit bad_par);
        for (int i = 0; i < nbits; i++) begin
            int  ng;
            bit  b;
            bit  last;
            bit  rdy;
            ng = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((i > 0) ? 1 : 0) : int'($urandom_range(0, 2));
            for (int g = 0; g < ng; g++) begin
                rdy = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
                cycle(0, 1'($urandom), 1'($urandom), rdy, 0, word, 0, 0, (i > 0) || partial);
            end
            last = (i == F - 1);
            b    = (i < W) ? word[i] : ((^word) ^ bad_par);
            rdy  = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1)
                   || (rdy_mode == 3 && last);
            cycle(1, b, i == 0, rdy, last && !bad_par, word,
                  (i == 0) && partial, last && bad_par, !last);
        end
        partial = (nbits < F);
    endtask

    task automatic drain_expect(input logic [W-1:0] exp);
        check("drain_valid", out_valid, 1);
        check("drain_data", out_data, exp);
        cycle(0, 0, 0, 1, 0, '0, 0, 0, partial);
    endtask

    initial begin
        int o0;
        int f0;
        int e0;
        rst = 1; sin = 0; sin_valid = 0; sof = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {overflow, frame_err, parity_err}, 0);
        rst = 0;

        // Contiguous A5: visible one cycle after the last bit.
        send_frame(8'hA5, F, 0, 0, 0);
        check("a5_valid", out_valid, 1);
        check("a5_data", out_data, 8'hA5);
        check("a5_busy", busy, 0);
        drain_expect(8'hA5);
        $display("txn a5 done checks=%0d", checks);

        // Gapped 3C: no error pulses.
        e0 = ovf_cnt + ferr_cnt + perr_cnt;
        send_frame(8'h3C, F, 1, 0, 0);
        check("3c_no_err", ovf_cnt + ferr_cnt + perr_cnt - e0, 0);
        drain_expect(8'h3C);
        $display("txn 3c done checks=%0d", checks);

        // Five words into a four-entry buffer with no consumer.
        o0 = ovf_cnt;
        for (int k = 1; k <= 5; k++) send_frame(W'(k), F, 0, 0, 0);
        check("ovf_count", ovf_cnt - o0, 1);
        for (int k = 1; k <= 4; k++) drain_expect(W'(k));
        check("ovf_empty", out_valid, 0);
        $display("txn overflow done checks=%0d", checks);

        // Aborted FF frame followed by 12.
        f0 = ferr_cnt;
        send_frame(8'hFF, 4, 0, 0, 0);
        check("abort_busy", busy, 1);
        send_frame(8'h12, F, 0, 0, 0);
        check("ferr_count", ferr_cnt - f0, 1);
        drain_expect(8'h12);
        check("ferr_empty", out_valid, 0);
        $display("txn frame_err done checks=%0d", checks);

        // Full buffer, commit and pop on the same edge.
        o0 = ovf_cnt;
        send_frame(8'hA1, F, 0, 0, 0);
        send_frame(8'hA2, F, 0, 0, 0);
        send_frame(8'hA3, F, 0, 0, 0);
        send_frame(8'hA4, F, 0, 0, 0);
        send_frame(8'hB5, F, 0, 3, 0);
        check("simul_no_ovf", ovf_cnt - o0, 0);
        drain_expect(8'hA2);
        drain_expect(8'hA3);
        drain_expect(8'hA4);
        drain_expect(8'hB5);
        check("simul_empty", out_valid, 0);
        $display("txn simultaneous done checks=%0d", checks);

`ifdef SERIAL_WORD_RX_PARITY_EN
        e0 = perr_cnt;
        send_frame(8'h07, F, 0, 0, 0);
        drain_expect(8'h07);
        send_frame(8'h07, F, 0, 0, 1);
        check("par_err_count", perr_cnt - e0, 1);
        check("par_nothing", out_valid, 0);
        $display("txn parity done checks=%0d", checks);
`endif

        // Reset mid-frame with words buffered.
        send_frame(8'h55, F, 0, 0, 0);
        send_frame(8'h66, 3, 0, 0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pulses", {overflow, frame_err, parity_err}, 0);
        rst = 0;
        model_q.delete();
        partial = 0;
        $display("txn mid_reset done checks=%0d", checks);

        // Randomized frames, gaps, aborts and consumer back-pressure.
        for (int n = 0; n < 60; n++) begin
            int nb;
            nb = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, F - 1)) : F;
            send_frame(W'($urandom), nb, 2, 2, (PB == 1) && ($urandom_range(0, 4) == 0));
            $display("txn random %0d bits=%0d queued=%0d", n, nb, model_q.size());
        end
        for (int d = 0; d < DEPTH + 2; d++) cycle(0, 0, 0, 1, 0, '0, 0, 0, partial);
        check("final_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
